// File: rtl/exec_arith_branch_unit_if.sv
// Operand, opcode, flag and result bundle between decode/regfile and the
// execute-stage arithmetic/branch slice.
interface exec_arith_branch_unit_if #(
  parameter int W_OPR = 32,
  parameter int ADDR  = 32,
  parameter int W_OPC = 7,
  parameter int W_IMM = 16
);
  logic             stall_i;
  logic             v_i;
  logic [ADDR-1:0]  pc_i;
  logic [W_OPC-1:0] opecode_i;
  logic [W_OPR-1:0] opr0_i;
  logic [W_OPR-1:0] opr1_i;
  logic             immf_i;
  logic             immsign_i;
  logic [W_IMM-1:0] imm_i;
  logic             cmp_c_i;
  logic             cmp_z_i;
  logic             cmp_s_i;
  logic             cmp_v_i;
  logic [W_OPR-1:0] result_add_o;
  logic [W_OPR-1:0] result_abs_o;
  logic             branch_o;
  logic [ADDR-1:0]  branch_addr_o;
  logic [3:0]       flags_o;

  modport master (
    output stall_i, v_i, pc_i, opecode_i, opr0_i, opr1_i, immf_i, immsign_i, imm_i,
           cmp_c_i, cmp_z_i, cmp_s_i, cmp_v_i,
    input  result_add_o, result_abs_o, branch_o, branch_addr_o, flags_o
  );

  modport slave (
    input  stall_i, v_i, pc_i, opecode_i, opr0_i, opr1_i, immf_i, immsign_i, imm_i,
           cmp_c_i, cmp_z_i, cmp_s_i, cmp_v_i,
    output result_add_o, result_abs_o, branch_o, branch_addr_o, flags_o
  );
endinterface

// File: rtl/exec_arith_branch_unit.sv
// Execute-stage slice: ADD/SUB adder, ABS unit, branch resolver and the
// architectural {C,Z,S,V} flag register that conditional branches read.
module exec_arith_branch_unit #(
  parameter int W_OPR = 32,
  parameter int ADDR  = 32,
  parameter int W_OPC = 7,
  parameter int W_IMM = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  exec_arith_branch_unit_if.slave     bus
);

  localparam logic [W_OPC-1:0] OPC_CMP = W_OPC'(7'h04);
  localparam logic [W_OPC-1:0] OPC_J   = W_OPC'(7'h1C);
  localparam logic [W_OPC-1:0] OPC_JA  = W_OPC'(7'h1D);

  logic [W_OPR-1:0] op1_s;
  logic [W_OPR-1:0] result_add_s;
  logic [W_OPR-1:0] result_abs_s;
  logic [ADDR-1:0]  op1_addr_s;
  logic [ADDR-1:0]  branch_addr_s;
  logic             is_j_s;
  logic             is_ja_s;
  logic             cond_s;
  logic             branch_s;
  logic [3:0]       flags_d;
  logic [3:0]       flags_q;

  // Operand selection, adder and ABS
  always_comb begin
    op1_s = bus.opr1_i;
    if (bus.immf_i) begin
      if (bus.immsign_i) begin
        op1_s = {{(W_OPR-W_IMM){bus.imm_i[W_IMM-1]}}, bus.imm_i};
      end else begin
        op1_s = {{(W_OPR-W_IMM){1'b0}}, bus.imm_i};
      end
    end else begin
      op1_s = bus.opr1_i;
    end

    if (bus.opecode_i[0]) begin
      result_add_s = bus.opr0_i - op1_s;
    end else begin
      result_add_s = bus.opr0_i + op1_s;
    end

    // The most negative value maps onto itself, as two's complement negation does.
    if (op1_s[W_OPR-1]) begin
      result_abs_s = {W_OPR{1'b0}} - op1_s;
    end else begin
      result_abs_s = op1_s;
    end
  end

  // Condition code evaluated against the registered flags {C,Z,S,V}
  always_comb begin
    cond_s = 1'b0;
    case (bus.opr0_i[3:0])
      4'd0:    cond_s = 1'b1;
      4'd1:    cond_s = flags_q[2];
      4'd2:    cond_s = ~flags_q[2];
      4'd3:    cond_s = flags_q[3];
      4'd4:    cond_s = ~flags_q[3];
      4'd5:    cond_s = flags_q[1];
      4'd6:    cond_s = ~flags_q[1];
      4'd7:    cond_s = flags_q[0];
      4'd8:    cond_s = ~flags_q[0];
      4'd9:    cond_s = ~flags_q[3] & ~flags_q[2];
      4'd10:   cond_s = flags_q[3] | flags_q[2];
      4'd11:   cond_s = (flags_q[1] == flags_q[0]);
      4'd12:   cond_s = (flags_q[1] != flags_q[0]);
      4'd13:   cond_s = ~flags_q[2] & (flags_q[1] == flags_q[0]);
      4'd14:   cond_s = flags_q[2] | (flags_q[1] != flags_q[0]);
      4'd15:   cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
  end

  // Branch target and taken decision; stall does not gate the branch
  always_comb begin
    is_j_s     = (bus.opecode_i == OPC_J);
    is_ja_s    = (bus.opecode_i == OPC_JA);
    op1_addr_s = ADDR'(op1_s);
    if (is_j_s) begin
      branch_addr_s = bus.pc_i + op1_addr_s;
    end else if (is_ja_s) begin
      branch_addr_s = op1_addr_s;
    end else begin
      branch_addr_s = {ADDR{1'b0}};
    end
    branch_s = bus.v_i & (is_j_s | is_ja_s) & cond_s;
  end

  // Next flag value: load compare flags on a valid, unstalled CMP
  always_comb begin
    flags_d = flags_q;
    if (!bus.stall_i && bus.v_i && (bus.opecode_i == OPC_CMP)) begin
      flags_d = {bus.cmp_c_i, bus.cmp_z_i, bus.cmp_s_i, bus.cmp_v_i};
    end else begin
      flags_d = flags_q;
    end
  end

  // Architectural flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign bus.result_add_o  = result_add_s;
  assign bus.result_abs_o  = result_abs_s;
  assign bus.branch_o      = branch_s;
  assign bus.branch_addr_o = branch_addr_s;
  assign bus.flags_o       = flags_q;

endmodule

// File: tb/tb_exec_arith_branch_unit.sv
// Self-checking bench for exec_arith_branch_unit: directed cases followed by
// random stimulus compared against an arithmetic reference model.
module tb_exec_arith_branch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [3:0] mf;   // model flags {C,Z,S,V}

  exec_arith_branch_unit_if bus ();

  exec_arith_branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] m_op1(logic immf, logic immsign, logic [15:0] imm, logic [31:0] opr1);
    longint val;
    if (!immf) return opr1;
    val = longint'(imm);
    if (immsign && val >= 32768) val = val - 65536;
    return 32'(val);
  endfunction

  function automatic logic [31:0] m_add(logic [6:0] opc, logic [31:0] a, logic [31:0] b);
    longint r;
    if (opc[0]) r = longint'(a) - longint'(b);
    else        r = longint'(a) + longint'(b);
    return 32'(r);
  endfunction

  function automatic logic [31:0] m_abs(logic [31:0] b);
    if (longint'(b) >= 64'sd2147483648) return 32'(64'sd4294967296 - longint'(b));
    return b;
  endfunction

  function automatic bit m_cond(logic [3:0] cc, logic [3:0] f);
    bit c, z, s, v;
    c = f[3]; z = f[2]; s = f[1]; v = f[0];
    case (int'(cc))
      0:  return 1'b1;
      1:  return z;
      2:  return !z;
      3:  return c;
      4:  return !c;
      5:  return s;
      6:  return !s;
      7:  return v;
      8:  return !v;
      9:  return !c && !z;
      10: return c || z;
      11: return s == v;
      12: return s != v;
      13: return !z && (s == v);
      14: return z || (s != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, settle, and compare every combinational output with the model.
  task automatic drive(input logic stall, input logic v, input logic [31:0] pc, input logic [6:0] opc,
                       input logic [31:0] opr0, input logic [31:0] opr1, input logic immf,
                       input logic immsign, input logic [15:0] imm, input logic [3:0] cmp);
    logic [31:0] op1;
    logic [31:0] e_addr;
    bit          is_br;
    bus.stall_i = stall; bus.v_i = v; bus.pc_i = pc; bus.opecode_i = opc;
    bus.opr0_i = opr0; bus.opr1_i = opr1; bus.immf_i = immf; bus.immsign_i = immsign;
    bus.imm_i = imm;
    bus.cmp_c_i = cmp[3]; bus.cmp_z_i = cmp[2]; bus.cmp_s_i = cmp[1]; bus.cmp_v_i = cmp[0];
    #2;
    op1   = m_op1(immf, immsign, imm, opr1);
    is_br = (opc == 7'h1C) || (opc == 7'h1D);
    if (opc == 7'h1C)      e_addr = 32'(longint'(pc) + longint'(op1));
    else if (opc == 7'h1D) e_addr = op1;
    else                   e_addr = 32'd0;
    chk("result_add", 64'(bus.result_add_o), 64'(m_add(opc, opr0, op1)));
    chk("result_abs", 64'(bus.result_abs_o), 64'(m_abs(op1)));
    chk("branch", 64'(bus.branch_o), 64'(v && is_br && m_cond(opr0[3:0], mf)));
    chk("branch_addr", 64'(bus.branch_addr_o), 64'(e_addr));
    chk("flags_pre", 64'(bus.flags_o), 64'(mf));
  endtask

  // One rising edge: update model flags, check the register, return to the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) mf = 4'b0000;
    else if (!bus.stall_i && bus.v_i && bus.opecode_i == 7'h04)
      mf = {bus.cmp_c_i, bus.cmp_z_i, bus.cmp_s_i, bus.cmp_v_i};
    #1;
    chk("flags", 64'(bus.flags_o), 64'(mf));
    @(negedge clk);
  endtask

  initial begin
    logic [6:0] opc_tbl [8];
    logic [6:0] opc;
    n_checks = 0;
    n_fail   = 0;
    mf       = 4'b0000;
    opc_tbl  = '{7'h00, 7'h01, 7'h04, 7'h05, 7'h1C, 7'h1D, 7'h04, 7'h1C};
    reset    = 1'b0;

    // Reset: flags clear, branch quiet while v_i=0, even with a CMP presented
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b1111);
    tick();
    chk("reset_flags", 64'(bus.flags_o), 64'h0);
    chk("reset_branch", 64'(bus.branch_o), 64'h0);
    reset = 1'b1;

    // ADD/SUB with sign/zero-extended immediates
    drive(1'b0, 1'b0, 32'h0, 7'h00, 32'd5, 32'h0, 1'b1, 1'b1, 16'hFFFF, 4'h0);
    chk("add_simm", 64'(bus.result_add_o), 64'h4);
    tick();
    drive(1'b0, 1'b0, 32'h0, 7'h01, 32'd0, 32'd1, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("sub_wrap", 64'(bus.result_add_o), 64'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 7'h00, 32'd1, 32'h0, 1'b1, 1'b0, 16'hFFFF, 4'h0);
    chk("add_zimm", 64'(bus.result_add_o), 64'h0001_0000);
    tick();

    // ABS
    drive(1'b0, 1'b0, 32'h0, 7'h05, 32'h0, 32'hFFFF_FFF6, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("abs_neg", 64'(bus.result_abs_o), 64'd10);
    drive(1'b0, 1'b0, 32'h0, 7'h05, 32'h0, 32'd7, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("abs_pos", 64'(bus.result_abs_o), 64'd7);
    drive(1'b0, 1'b0, 32'h0, 7'h05, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("abs_min", 64'(bus.result_abs_o), 64'h8000_0000);
    tick();

    // Flags: load, hold on stall, hold on invalid
    drive(1'b0, 1'b1, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b1010);
    tick();
    chk("cmp_load", 64'(bus.flags_o), 64'b1010);
    drive(1'b1, 1'b1, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b0101);
    tick();
    chk("cmp_stall", 64'(bus.flags_o), 64'b1010);
    drive(1'b0, 1'b0, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b0101);
    tick();
    chk("cmp_invalid", 64'(bus.flags_o), 64'b1010);

    // Relative jump with wrap, and with v_i low
    drive(1'b0, 1'b1, 32'h100, 7'h1C, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("j_taken", 64'(bus.branch_o), 64'h1);
    chk("j_addr", 64'(bus.branch_addr_o), 64'hF0);
    drive(1'b0, 1'b0, 32'h100, 7'h1C, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("j_invalid", 64'(bus.branch_o), 64'h0);
    tick();

    // Conditional JA on Z=1
    drive(1'b0, 1'b1, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b0100);
    tick();
    drive(1'b0, 1'b1, 32'h0, 7'h1D, 32'd1, 32'h2000, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("ja_z", 64'(bus.branch_o), 64'h1);
    chk("ja_addr", 64'(bus.branch_addr_o), 64'h2000);
    drive(1'b0, 1'b1, 32'h0, 7'h1D, 32'd2, 32'h2000, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("ja_nz", 64'(bus.branch_o), 64'h0);
    drive(1'b0, 1'b1, 32'h0, 7'h1D, 32'd15, 32'h2000, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("ja_never", 64'(bus.branch_o), 64'h0);
    tick();
    // A CMP clearing Z is not visible until the following cycle
    drive(1'b0, 1'b1, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b0000);
    chk("cmp_same_cycle", 64'(bus.flags_o), 64'b0100);
    tick();
    drive(1'b0, 1'b1, 32'h0, 7'h1D, 32'd1, 32'h3000, 1'b0, 1'b0, 16'h0, 4'h0);
    chk("ja_after_cmp", 64'(bus.branch_o), 64'h0);
    tick();

    // Asynchronous reset between clock edges
    drive(1'b0, 1'b1, 32'h0, 7'h04, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'b1111);
    tick();
    chk("flags_all", 64'(bus.flags_o), 64'b1111);
    drive(1'b1, 1'b0, 32'h0, 7'h00, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 4'h0);
    reset = 1'b0;
    #1;
    mf = 4'b0000;
    chk("async_reset", 64'(bus.flags_o), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) opc = 7'($urandom);
      else                           opc = opc_tbl[$urandom_range(0, 7)];
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), $urandom, opc,
            $urandom, $urandom, 1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
